// File: rtl/gps_frame_rx.sv
// gps_frame_rx: byte-stream receiver for framed GPS fixes.
// A frame is SYNC_BYTE, a payload of latitude/longitude/speed (MSB byte
// first) and an XOR checksum byte. Good frames are committed atomically to
// the outputs; bad or stalled frames only bump a saturating error counter.
// A stale timer drops fix_valid when no good frame arrives for too long.
module gps_frame_rx #(
  parameter int          COORD_W      = 32,
  parameter int          SPEED_W      = 16,
  parameter logic [7:0]  SYNC_BYTE    = 8'hA5,
  parameter int          GAP_CYCLES   = 1024,
  parameter int          STALE_CYCLES = 1000000,
  parameter int          ERR_W        = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [7:0]         rx_data,
  input  logic               rx_valid,
  output logic [COORD_W-1:0] latitude,
  output logic [COORD_W-1:0] longitude,
  output logic [SPEED_W-1:0] speed,
  output logic               fix_update,
  output logic               fix_valid,
  output logic [ERR_W-1:0]   err_cnt
);

  localparam int NBYTES  = (2 * COORD_W + SPEED_W) / 8;
  localparam int SH_W    = 2 * COORD_W + SPEED_W;
  localparam int CNT_W   = $clog2(NBYTES + 1);
  localparam int GAP_W   = $clog2(GAP_CYCLES + 1);
  localparam int STALE_W = $clog2(STALE_CYCLES + 1);

  localparam logic [CNT_W-1:0]   LAST_BYTE  = CNT_W'(NBYTES - 1);
  localparam logic [GAP_W-1:0]   GAP_LAST   = GAP_W'(GAP_CYCLES - 1);
  localparam logic [STALE_W-1:0] STALE_LOAD = STALE_W'(STALE_CYCLES);

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    PAYLOAD = 2'd1,
    CHECK   = 2'd2
  } state_t;

  state_t               state_q,  state_d;
  logic [CNT_W-1:0]     cnt_q,    cnt_d;
  logic [7:0]           acc_q,    acc_d;
  logic [SH_W-1:0]      shadow_q, shadow_d;
  logic [GAP_W-1:0]     gap_q,    gap_d;
  logic [STALE_W-1:0]   stale_q,  stale_d;
  logic [COORD_W-1:0]   lat_q,    lat_d;
  logic [COORD_W-1:0]   lon_q,    lon_d;
  logic [SPEED_W-1:0]   spd_q,    spd_d;
  logic                 upd_q,    upd_d;
  logic                 valid_q,  valid_d;
  logic [ERR_W-1:0]     err_q,    err_d;
  logic                 commit;
  logic                 errInc;

  // Next-state logic: frame FSM, shadow capture, gap abort, commit, stale timer, error count
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    shadow_d = shadow_q;
    gap_d    = gap_q;
    stale_d  = stale_q;
    lat_d    = lat_q;
    lon_d    = lon_q;
    spd_d    = spd_q;
    upd_d    = 1'b0;
    valid_d  = valid_q;
    err_d    = err_q;
    commit   = 1'b0;
    errInc   = 1'b0;

    case (state_q)
      HUNT: begin
        gap_d = '0;
        if (rx_valid && (rx_data == SYNC_BYTE)) begin
          state_d = PAYLOAD;
          cnt_d   = '0;
          acc_d   = '0;
        end
      end

      PAYLOAD: begin
        if (rx_valid) begin
          gap_d    = '0;
          shadow_d = {shadow_q[SH_W-9:0], rx_data};
          acc_d    = acc_q ^ rx_data;
          cnt_d    = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_BYTE) begin
            state_d = CHECK;
          end
        end else if (gap_q == GAP_LAST) begin
          state_d = HUNT;
          gap_d   = '0;
          errInc  = 1'b1;
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end

      CHECK: begin
        if (rx_valid) begin
          gap_d   = '0;
          state_d = HUNT;
          if (rx_data == acc_q) begin
            commit = 1'b1;
          end else begin
            errInc = 1'b1;
          end
        end else if (gap_q == GAP_LAST) begin
          state_d = HUNT;
          gap_d   = '0;
          errInc  = 1'b1;
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end

      default: begin
        state_d = HUNT;
      end
    endcase

    // A commit reloads the timer even if it would expire this same cycle
    if (commit) begin
      lat_d   = shadow_q[SH_W-1 -: COORD_W];
      lon_d   = shadow_q[SPEED_W+COORD_W-1 -: COORD_W];
      spd_d   = shadow_q[SPEED_W-1:0];
      upd_d   = 1'b1;
      valid_d = 1'b1;
      stale_d = STALE_LOAD;
    end else if (valid_q) begin
      if (stale_q <= STALE_W'(1)) begin
        stale_d = '0;
        valid_d = 1'b0;
      end else begin
        stale_d = stale_q - STALE_W'(1);
      end
    end

    if (errInc && (err_q != '1)) begin
      err_d = err_q + ERR_W'(1);
    end
  end

  // State and output registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= HUNT;
      cnt_q    <= '0;
      acc_q    <= '0;
      shadow_q <= '0;
      gap_q    <= '0;
      stale_q  <= '0;
      lat_q    <= '0;
      lon_q    <= '0;
      spd_q    <= '0;
      upd_q    <= 1'b0;
      valid_q  <= 1'b0;
      err_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      shadow_q <= shadow_d;
      gap_q    <= gap_d;
      stale_q  <= stale_d;
      lat_q    <= lat_d;
      lon_q    <= lon_d;
      spd_q    <= spd_d;
      upd_q    <= upd_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
    end
  end

  assign latitude   = lat_q;
  assign longitude  = lon_q;
  assign speed      = spd_q;
  assign fix_update = upd_q;
  assign fix_valid  = valid_q;
  assign err_cnt    = err_q;

endmodule

// File: tb/tb_gps_frame_rx.sv
// tb_gps_frame_rx: directed bench for gps_frame_rx with short gap and
// stale timeouts so that both timers can be exercised quickly.
module tb_gps_frame_rx;

  logic        clk;
  logic        reset_n;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [31:0] latitude;
  logic [31:0] longitude;
  logic [15:0] speed;
  logic        fix_update;
  logic        fix_valid;
  logic [7:0]  err_cnt;

  int checks;
  int errors;
  int expErr;

  gps_frame_rx #(
    .COORD_W      (32),
    .SPEED_W      (16),
    .SYNC_BYTE    (8'hA5),
    .GAP_CYCLES   (16),
    .STALE_CYCLES (100),
    .ERR_W        (8)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .latitude   (latitude),
    .longitude  (longitude),
    .speed      (speed),
    .fix_update (fix_update),
    .fix_valid  (fix_valid),
    .err_cnt    (err_cnt)
  );

  // Free-running clock, 10 time units per period
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Present one byte for one cycle; returns 1 unit after the sampling edge
  task automatic sendByte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Sync, ten payload bytes MSB first, checksum
  task automatic sendFrame(input logic [79:0] pl, input logic [7:0] cs);
    sendByte(8'hA5);
    for (int i = 9; i >= 0; i--) begin
      sendByte(pl[i*8 +: 8]);
    end
    sendByte(cs);
  endtask

  task automatic test_reset;
    rx_data  = 8'h00;
    rx_valid = 1'b0;
    reset_n  = 1'b0;
    idle(3);
    checks += 6;
    if (latitude !== 32'h0)  begin errors++; $display("[TB] FAIL reset_lat got %h want %h", latitude, 32'h0); end
    if (longitude !== 32'h0) begin errors++; $display("[TB] FAIL reset_lon got %h want %h", longitude, 32'h0); end
    if (speed !== 16'h0)     begin errors++; $display("[TB] FAIL reset_speed got %h want %h", speed, 16'h0); end
    if (fix_update !== 1'b0) begin errors++; $display("[TB] FAIL reset_upd got %b want 0", fix_update); end
    if (fix_valid !== 1'b0)  begin errors++; $display("[TB] FAIL reset_valid got %b want 0", fix_valid); end
    if (err_cnt !== 8'h0)    begin errors++; $display("[TB] FAIL reset_err got %h want 00", err_cnt); end
    reset_n = 1'b1;
    idle(2);
  endtask

  task automatic test_good_frame;
    $display("[TB] good frame");
    sendByte(8'hA5);
    foreach (pl_bytes_good[i]) sendByte(pl_bytes_good[i]);
    checks += 2;
    if (fix_update !== 1'b0)   begin errors++; $display("[TB] FAIL good_pre_upd got %b want 0", fix_update); end
    if (latitude !== 32'h0)    begin errors++; $display("[TB] FAIL good_pre_lat got %h want %h", latitude, 32'h0); end
    sendByte(8'hB4);
    checks += 5;
    if (latitude !== 32'h12345678)  begin errors++; $display("[TB] FAIL good_lat got %h want 12345678", latitude); end
    if (longitude !== 32'h87654321) begin errors++; $display("[TB] FAIL good_lon got %h want 87654321", longitude); end
    if (speed !== 16'd60)           begin errors++; $display("[TB] FAIL good_speed got %0d want 60", speed); end
    if (fix_update !== 1'b1)        begin errors++; $display("[TB] FAIL good_upd got %b want 1", fix_update); end
    if (fix_valid !== 1'b1)         begin errors++; $display("[TB] FAIL good_valid got %b want 1", fix_valid); end
    idle(1);
    checks += 1;
    if (fix_update !== 1'b0) begin errors++; $display("[TB] FAIL good_upd_pulse got %b want 0", fix_update); end
  endtask

  task automatic test_bad_checksum;
    $display("[TB] bad checksum");
    sendFrame(80'h12345678_87654321_003C, 8'hB5);
    expErr++;
    checks += 4;
    if (err_cnt !== expErr[7:0])    begin errors++; $display("[TB] FAIL bad_err got %0d want %0d", err_cnt, expErr); end
    if (fix_update !== 1'b0)        begin errors++; $display("[TB] FAIL bad_upd got %b want 0", fix_update); end
    if (latitude !== 32'h12345678)  begin errors++; $display("[TB] FAIL bad_lat got %h want 12345678", latitude); end
    if (speed !== 16'h003C)         begin errors++; $display("[TB] FAIL bad_speed got %h want 003c", speed); end
    idle(1);
    checks += 1;
    if (fix_update !== 1'b0) begin errors++; $display("[TB] FAIL bad_upd_late got %b want 0", fix_update); end
  endtask

  task automatic test_sync_in_payload;
    $display("[TB] sync byte inside payload and as checksum");
    sendByte(8'h00);
    sendByte(8'hFF);
    sendByte(8'h3C);
    sendFrame(80'h1122A544_AABBCCDD_0077, 8'hA5);
    checks += 5;
    if (latitude !== 32'h1122A544)  begin errors++; $display("[TB] FAIL sync_lat got %h want 1122a544", latitude); end
    if (longitude !== 32'hAABBCCDD) begin errors++; $display("[TB] FAIL sync_lon got %h want aabbccdd", longitude); end
    if (speed !== 16'h0077)         begin errors++; $display("[TB] FAIL sync_speed got %h want 0077", speed); end
    if (fix_update !== 1'b1)        begin errors++; $display("[TB] FAIL sync_upd got %b want 1", fix_update); end
    if (err_cnt !== expErr[7:0])    begin errors++; $display("[TB] FAIL sync_err got %0d want %0d", err_cnt, expErr); end
  endtask

  task automatic test_gap_abort;
    $display("[TB] inter-byte gap");
    // 15 idle cycles is just inside the limit; the frame must survive
    sendByte(8'hA5);
    sendByte(8'h01); sendByte(8'h02); sendByte(8'h03); sendByte(8'h04);
    idle(15);
    checks += 1;
    if (err_cnt !== expErr[7:0]) begin errors++; $display("[TB] FAIL gap15_err got %0d want %0d", err_cnt, expErr); end
    for (int b = 5; b <= 10; b++) sendByte(8'(b));
    sendByte(8'h0B);
    checks += 3;
    if (latitude !== 32'h01020304)  begin errors++; $display("[TB] FAIL gap15_lat got %h want 01020304", latitude); end
    if (longitude !== 32'h05060708) begin errors++; $display("[TB] FAIL gap15_lon got %h want 05060708", longitude); end
    if (speed !== 16'h090A)         begin errors++; $display("[TB] FAIL gap15_speed got %h want 090a", speed); end
    // 16 idle cycles aborts the frame
    sendByte(8'hA5);
    sendByte(8'h01); sendByte(8'h02); sendByte(8'h03); sendByte(8'h04);
    idle(15);
    checks += 1;
    if (err_cnt !== expErr[7:0]) begin errors++; $display("[TB] FAIL gap16_early got %0d want %0d", err_cnt, expErr); end
    idle(1);
    expErr++;
    checks += 2;
    if (err_cnt !== expErr[7:0])   begin errors++; $display("[TB] FAIL gap16_err got %0d want %0d", err_cnt, expErr); end
    if (latitude !== 32'h01020304) begin errors++; $display("[TB] FAIL gap16_lat got %h want 01020304", latitude); end
    sendFrame(80'h12345678_87654321_003C, 8'hB4);
    checks += 2;
    if (fix_update !== 1'b1)       begin errors++; $display("[TB] FAIL gap_next_upd got %b want 1", fix_update); end
    if (latitude !== 32'h12345678) begin errors++; $display("[TB] FAIL gap_next_lat got %h want 12345678", latitude); end
  endtask

  task automatic test_stale;
    $display("[TB] stale timer");
    sendFrame(80'h01020304_05060708_090A, 8'h0B);
    idle(99);
    checks += 1;
    if (fix_valid !== 1'b1) begin errors++; $display("[TB] FAIL stale_99 got %b want 1", fix_valid); end
    idle(1);
    checks += 3;
    if (fix_valid !== 1'b0)        begin errors++; $display("[TB] FAIL stale_100 got %b want 0", fix_valid); end
    if (latitude !== 32'h01020304) begin errors++; $display("[TB] FAIL stale_lat got %h want 01020304", latitude); end
    if (speed !== 16'h090A)        begin errors++; $display("[TB] FAIL stale_speed got %h want 090a", speed); end
    sendFrame(80'h12345678_87654321_003C, 8'hB4);
    checks += 1;
    if (fix_valid !== 1'b1) begin errors++; $display("[TB] FAIL stale_refix got %b want 1", fix_valid); end
    // Next commit lands on the very edge where the timer would expire
    idle(88);
    sendFrame(80'h01020304_05060708_090A, 8'h0B);
    checks += 2;
    if (fix_update !== 1'b1) begin errors++; $display("[TB] FAIL stale_prio_upd got %b want 1", fix_update); end
    if (fix_valid !== 1'b1)  begin errors++; $display("[TB] FAIL stale_prio_valid got %b want 1", fix_valid); end
    idle(99);
    checks += 1;
    if (fix_valid !== 1'b1) begin errors++; $display("[TB] FAIL stale_reload got %b want 1", fix_valid); end
  endtask

  task automatic test_err_saturate;
    $display("[TB] error saturation");
    while (expErr < 255) begin
      sendFrame(80'h12345678_87654321_003C, 8'h00);
      expErr++;
    end
    checks += 1;
    if (err_cnt !== 8'hFF) begin errors++; $display("[TB] FAIL sat_255 got %0d want 255", err_cnt); end
    sendFrame(80'h12345678_87654321_003C, 8'h00);
    checks += 1;
    if (err_cnt !== 8'hFF) begin errors++; $display("[TB] FAIL sat_hold got %0d want 255", err_cnt); end
  endtask

  task automatic test_reset_mid_frame;
    $display("[TB] reset mid payload");
    sendByte(8'hA5);
    sendByte(8'h12); sendByte(8'h34); sendByte(8'h56);
    #2;
    reset_n = 1'b0;
    #1;
    checks += 5;
    if (latitude !== 32'h0)  begin errors++; $display("[TB] FAIL rst_lat got %h want 0", latitude); end
    if (speed !== 16'h0)     begin errors++; $display("[TB] FAIL rst_speed got %h want 0", speed); end
    if (fix_valid !== 1'b0)  begin errors++; $display("[TB] FAIL rst_valid got %b want 0", fix_valid); end
    if (fix_update !== 1'b0) begin errors++; $display("[TB] FAIL rst_upd got %b want 0", fix_update); end
    if (err_cnt !== 8'h0)    begin errors++; $display("[TB] FAIL rst_err got %0d want 0", err_cnt); end
    @(posedge clk);
    #3;
    reset_n = 1'b1;
    idle(1);
    // Tail of the interrupted frame must be ignored
    sendByte(8'h78); sendByte(8'h87); sendByte(8'h65); sendByte(8'h43);
    sendByte(8'h21); sendByte(8'h00); sendByte(8'h3C); sendByte(8'hB4);
    idle(1);
    checks += 2;
    if (latitude !== 32'h0) begin errors++; $display("[TB] FAIL rst_tail_lat got %h want 0", latitude); end
    if (err_cnt !== 8'h0)   begin errors++; $display("[TB] FAIL rst_tail_err got %0d want 0", err_cnt); end
    sendFrame(80'h1122A544_AABBCCDD_0077, 8'hA5);
    checks += 2;
    if (latitude !== 32'h1122A544) begin errors++; $display("[TB] FAIL rst_next_lat got %h want 1122a544", latitude); end
    if (fix_valid !== 1'b1)        begin errors++; $display("[TB] FAIL rst_next_valid got %b want 1", fix_valid); end
  endtask

  logic [7:0] pl_bytes_good [10];

  // Run each scenario in order, then report
  initial begin
    checks = 0;
    errors = 0;
    expErr = 0;
    pl_bytes_good = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h87, 8'h65, 8'h43, 8'h21, 8'h00, 8'h3C};
    test_reset();
    test_good_frame();
    test_bad_checksum();
    test_sync_in_payload();
    test_gap_abort();
    test_stale();
    test_err_saturate();
    test_reset_mid_frame();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
